// File: rtl/mips_run_mon_pkg.sv
// rtl/mips_run_mon_pkg.sv - shared state type and MISR constants for the MIPS run monitor
package mips_run_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD_RST,
        RUN,
        DONE
    } run_state_t;

    localparam logic [15:0] SIG_SEED = 16'hFFFF;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] SIG_POLY = 16'hB400;

endpackage

// File: rtl/mips_sig_misr.sv
// rtl/mips_sig_misr.sv - Galois MISR folding one data word per enabled cycle into a signature
module mips_sig_misr #(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(mips_run_mon_pkg::SIG_POLY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sig
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig <= seed;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= ((sig >> 1) ^ (sig[0] ? POLY : '0)) ^ din;
        end
    end

endmodule

// File: rtl/mips_run_monitor.sv
// rtl/mips_run_monitor.sv - core run controller with halt/timeout detection; MISR signature under MIPS_RUN_MON_SIG_EN
module mips_run_monitor #(
    parameter int                DATA_W       = 16,
    parameter int                PC_W         = 16,
    parameter int                MAX_CYCLES   = 1024,
    parameter int                RESET_CYCLES = 2,
    parameter int                HALT_REPEAT  = 2,
    parameter logic [DATA_W-1:0] SIG_SEED     = DATA_W'(mips_run_mon_pkg::SIG_SEED),
    localparam int               CNT_W        = $clog2(MAX_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] result_i,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] signature
);

    import mips_run_mon_pkg::*;

    localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
    localparam int STALL_W = $clog2(HALT_REPEAT + 1);

    run_state_t         state;
    run_state_t         state_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_next;
    logic [PC_W-1:0]    prev_pc;
    logic [CNT_W-1:0]   cnt_next;
    logic               accept;
    logic               pc_match;
    logic               halt_hit;
    logic               limit_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        cnt_next = cycle_count + 1'b1;
        // prev_pc is stale on the first RUN cycle, so a match there is ignored
        pc_match = (cycle_count != '0) && (pc_i == prev_pc);
        if (!pc_match) begin
            stall_next = '0;
        end else if (stall_cnt == STALL_W'(HALT_REPEAT)) begin
            stall_next = stall_cnt;
        end else begin
            stall_next = stall_cnt + 1'b1;
        end
        halt_hit  = (stall_next == STALL_W'(HALT_REPEAT));
        limit_hit = (cnt_next == CNT_W'(MAX_CYCLES));

        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = HOLD_RST;
            HOLD_RST:   if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) state_next = RUN;
            RUN:        if (halt_hit || limit_hit) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            hold_cnt    <= '0;
            stall_cnt   <= '0;
            prev_pc     <= '0;
        end else begin
            cpu_reset_n <= (state_next == RUN) || (state_next == DONE);
            busy        <= (state_next == HOLD_RST) || (state_next == RUN);
            done        <= (state_next == DONE);
            if (accept) begin
                cycle_count <= '0;
                halted      <= 1'b0;
                timeout     <= 1'b0;
                stall_cnt   <= '0;
                hold_cnt    <= '0;
            end else if (state == HOLD_RST) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (state == RUN) begin
                cycle_count <= cnt_next;
                stall_cnt   <= stall_next;
                prev_pc     <= pc_i;
                // halt takes priority when both end conditions land on one edge
                if (halt_hit) begin
                    halted <= 1'b1;
                end else if (limit_hit) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

`ifdef MIPS_RUN_MON_SIG_EN
    logic run_en;
    assign run_en = (state == RUN);

    mips_sig_misr #(
        .DATA_W (DATA_W),
        .POLY   (DATA_W'(SIG_POLY))
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .seed  (SIG_SEED),
        .en    (run_en),
        .din   (result_i),
        .sig   (signature)
    );
`else
    logic unused_result;
    assign unused_result = ^result_i;
    assign signature     = SIG_SEED;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// tb/tb_mips_run_monitor.sv - randomized self-checking bench for mips_run_monitor against a run-level model
module tb_mips_run_monitor;

    localparam int          MAXC = 20;
    localparam int          RC   = 2;
    localparam int          HR   = 2;
    localparam int          CW   = $clog2(MAXC + 1);
    localparam logic [15:0] SEED = 16'hFFFF;
    localparam logic [15:0] POLY = 16'hB400;
`ifdef MIPS_RUN_MON_SIG_EN
    localparam logic [15:0] SIG4 = 16'h197E;
`else
    localparam logic [15:0] SIG4 = 16'hFFFF;
`endif

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic [15:0]   pc_i     = '0;
    logic [15:0]   result_i = '0;
    logic          cpu_reset_n;
    logic          busy;
    logic          done;
    logic          halted;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [15:0]   signature;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] hseq [6] = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd6, 16'd6};

    mips_run_monitor #(
        .DATA_W       (16),
        .PC_W         (16),
        .MAX_CYCLES   (MAXC),
        .RESET_CYCLES (RC),
        .HALT_REPEAT  (HR),
        .SIG_SEED     (SEED)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc_i        (pc_i),
        .result_i    (result_i),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .halted      (halted),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .signature   (signature)
    );

    always #5 clk = ~clk;

    // Run-level model: a run is a hold countdown followed by a list of sampled PCs.
    bit          m_active  = 0;
    bit          m_ended   = 0;
    bit          m_halted  = 0;
    bit          m_timeout = 0;
    int          m_hold    = 0;
    logic [15:0] m_pcs [$];
    logic [15:0] m_sig     = SEED;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] d);
        return ((s >> 1) ^ (s[0] ? POLY : 16'h0000)) ^ d;
    endfunction

    function automatic bit repeated_tail();
        int n = m_pcs.size();
        if (n < HR + 1) return 0;
        for (int k = n - HR; k < n; k++)
            if (m_pcs[k] != m_pcs[n - HR - 1]) return 0;
        return 1;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_active = 0; m_ended = 0; m_halted = 0; m_timeout = 0;
            m_hold = 0; m_pcs.delete(); m_sig = SEED;
        end else if (start && (!m_active || m_ended)) begin
            m_active = 1; m_ended = 0; m_halted = 0; m_timeout = 0;
            m_hold = RC; m_pcs.delete(); m_sig = SEED;
        end else if (m_active && !m_ended) begin
            if (m_hold > 0) begin
                m_hold--;
            end else begin
                m_pcs.push_back(pc_i);
`ifdef MIPS_RUN_MON_SIG_EN
                m_sig = misr(m_sig, result_i);
`endif
                if (repeated_tail()) begin
                    m_halted = 1; m_ended = 1;
                end else if (m_pcs.size() == MAXC) begin
                    m_timeout = 1; m_ended = 1;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        check("cpu_reset_n", 32'(cpu_reset_n), 32'(m_active && (m_ended || m_hold == 0)));
        check("busy",        32'(busy),        32'(m_active && !m_ended));
        check("done",        32'(done),        32'(m_ended));
        check("halted",      32'(halted),      32'(m_halted));
        check("timeout",     32'(timeout),     32'(m_timeout));
        check("cycle_count", 32'(cycle_count), 32'(m_pcs.size()));
        check("signature",   32'(signature),   32'(m_sig));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_run(output int lows);
        lows = 0;
        while (!cpu_reset_n && lows < 8) begin
            lows++;
            step();
        end
    endtask

    task automatic feed(input logic [15:0] pc, input logic [15:0] res);
        pc_i     = pc;
        result_i = res;
        step();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 0);
        check({tag, "_busy"},        32'(busy),        0);
        check({tag, "_done"},        32'(done),        0);
        check({tag, "_halted"},      32'(halted),      0);
        check({tag, "_timeout"},     32'(timeout),     0);
        check({tag, "_count"},       32'(cycle_count), 0);
        check({tag, "_signature"},   32'(signature),   32'(SEED));
    endtask

    initial begin
        int lows;
        bit walk;
        repeat (2) step();
        check_reset_values("por");
        reset = 1'b0;
        step();

        // halt: PC 0,2,4,6,6,6
        pulse_start();
        check("start_busy", 32'(busy), 1);
        check("start_held", 32'(cpu_reset_n), 0);
        wait_run(lows);
        check("hold_len", lows, RC);
        for (int i = 0; i < 6; i++) feed(hseq[i], 16'(3 * i + 1));
        check("halt_done",    32'(done),        1);
        check("halt_halted",  32'(halted),      1);
        check("halt_timeout", 32'(timeout),     0);
        check("halt_count",   32'(cycle_count), 6);

        // timeout with a start pulse during RUN
        pulse_start();
        wait_run(lows);
        for (int i = 0; i < MAXC; i++) begin
            start = (i == 5);
            feed(16'(2 * i + 100), 16'($urandom));
            start = 1'b0;
        end
        check("to_done",    32'(done),        1);
        check("to_timeout", 32'(timeout),     1);
        check("to_halted",  32'(halted),      0);
        check("to_count",   32'(cycle_count), MAXC);
        repeat (3) step();
        check("to_frozen",  32'(cycle_count), MAXC);
        check("to_rst_n",   32'(cpu_reset_n), 1);

        // halt and limit on the same cycle
        pulse_start();
        wait_run(lows);
        for (int i = 0; i < MAXC; i++) feed((i < 17) ? 16'(2 * i) : 16'd34, 16'(i));
        check("prio_halted",  32'(halted),      1);
        check("prio_timeout", 32'(timeout),     0);
        check("prio_count",   32'(cycle_count), MAXC);

        // signature: four results of 1 then halt
        pulse_start();
        wait_run(lows);
        feed(16'd0, 16'h0001);
        feed(16'd2, 16'h0001);
        feed(16'd2, 16'h0001);
        feed(16'd2, 16'h0001);
        check("sig_halted", 32'(halted),      1);
        check("sig_count",  32'(cycle_count), 4);
        check("sig_value",  32'(signature),   32'(SIG4));

        // restart from DONE
        pulse_start();
        check("rs_done",   32'(done),        0);
        check("rs_halted", 32'(halted),      0);
        check("rs_count",  32'(cycle_count), 0);
        wait_run(lows);
        check("rs_hold_len", lows, RC);
        for (int i = 0; i < 6; i++) feed(hseq[i], 16'(3 * i + 1));
        check("rs_halted2", 32'(halted),      1);
        check("rs_count2",  32'(cycle_count), 6);

        // asynchronous reset mid-run, mid-cycle
        pulse_start();
        wait_run(lows);
        for (int i = 0; i < 3; i++) feed(16'(4 * i), 16'(i));
        #1 reset = 1'b1;
        #1 check_reset_values("async");
        step();
        reset = 1'b0;
        step();
        pulse_start();
        wait_run(lows);
        feed(16'd10, 16'h1234);
        check("post_rst_count", 32'(cycle_count), 1);

        // randomized runs
        for (int r = 0; r < 25; r++) begin
            walk = $urandom_range(0, 1) == 1;
            pulse_start();
            for (int j = 0; j < 45 && !done; j++) begin
                if (walk) pc_i = pc_i + 16'd2;
                else      pc_i = 16'(2 * $urandom_range(0, 2));
                result_i = 16'($urandom);
                start    = ($urandom_range(0, 7) == 0);
                reset    = ($urandom_range(0, 60) == 0);
                step();
                reset = 1'b0;
            end
            start = 1'b0;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_run_monitor.md
# mips_run_monitor

Parametrised run controller and self-checking monitor for the single-cycle MIPS core. On `start` it holds the core in reset for a programmable number of cycles, then releases it. While the core runs it counts cycles, folds every ALU result into a signature register, and ends the run on a halt (PC stuck) or a timeout. It replaces fixed-length, free-running simulation with a reusable block that reports a pass/fail status, and it can be instantiated in the bench or on an FPGA debug wrapper.

## Interface
- `DATA_W`, 16, width of the ALU result and the signature
- `PC_W`, 16, width of the PC
- `MAX_CYCLES`, 1024, run-cycle limit before timeout (≥1)
- `RESET_CYCLES`, 2, cycles `cpu_reset_n` is held low after start (≥1)
- `HALT_REPEAT`, 2, consecutive unchanged-PC cycles that mean halt (≥1)
- `SIG_SEED`, 16'hFFFF, signature initial value
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `start` in 1 — one-cycle run request
- `pc_i` in PC_W — core PC
- `result_i` in DATA_W — core ALU result
- `cpu_reset_n` out 1 — drives the core's active-low reset
- `busy` out 1 — high in HOLD_RST and RUN
- `done` out 1 — high in DONE
- `halted` out 1 — run ended by halt detection
- `timeout` out 1 — run ended by the cycle limit
- `cycle_count` out CNT_W — RUN cycles elapsed; CNT_W = $clog2(MAX_CYCLES+1)
- `signature` out DATA_W — result signature

## Operation
- FSM states: IDLE, HOLD_RST, RUN, DONE.
- IDLE: `start` → HOLD_RST. At the same edge: clear `cycle_count`, `halted`, `timeout`, and the stall counter; load `signature` = SIG_SEED.
- HOLD_RST: `cpu_reset_n`=0. A counter runs RESET_CYCLES cycles, then the FSM goes to RUN.
- RUN: `cpu_reset_n`=1. Each cycle:
  - `cycle_count`++.
  - `signature` ← MISR(`signature`, `result_i`).
  - Compare `pc_i` with the registered previous PC. The comparison is invalid on the first RUN cycle.
  - A match increments the stall counter. A mismatch clears it.
- Halt: the stall counter reaches HALT_REPEAT → set `halted`, go to DONE.
- Timeout: `cycle_count` reaches MAX_CYCLES without a halt → set `timeout`, go to DONE.
- Halt and timeout on the same cycle: halt wins. `halted`=1, `timeout`=0.
- DONE: all status outputs are frozen, and `cpu_reset_n` stays 1. `start` → HOLD_RST (restart with clear).
- `start` in HOLD_RST or RUN is ignored.
- `cycle_count` never exceeds MAX_CYCLES. The stall counter saturates at HALT_REPEAT.
- `reset` at any time, including mid-run, forces IDLE asynchronously.
- Reset values: `cpu_reset_n`=0 (core held), `busy`=0, `done`=0, `halted`=0, `timeout`=0, `cycle_count`=0, `signature`=SIG_SEED.
- IDLE keeps `cpu_reset_n`=0.

## Timing
- `start` sampled at edge N → `busy`=1 and `cpu_reset_n`=0 after edge N.
- `cpu_reset_n` rises after edge N+RESET_CYCLES.
- The first result is sampled at edge N+RESET_CYCLES+1.
- The terminating condition is detected at edge T → `done`=1, with `halted` or `timeout` valid, after edge T. That edge's signature update and count are included.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `MIPS_RUN_MON_SIG_EN` defined: the MISR is instantiated and `signature` updates in RUN.
- Undefined: no MISR logic, and `signature` stays at SIG_SEED. All other behaviour is identical.

## Structure
- Package `mips_run_mon_pkg`:
  - state enum `run_state_t` (IDLE, HOLD_RST, RUN, DONE);
  - default `SIG_SEED`;
  - MISR tap constant `SIG_POLY` = 16'hB400 (Galois, x^16+x^14+x^13+x^11+1).
- Sub-module `mips_sig_misr`:
  - parameters DATA_W and POLY;
  - ports clk, reset, load, seed, en, din, sig;
  - next = ((sig>>1) ^ (sig[0] ? POLY : 0)) ^ din.
- Everything else lives in `mips_run_monitor`.

## Test plan
All scenarios use MAX_CYCLES=20, RESET_CYCLES=2, HALT_REPEAT=2.
- Reset: assert `reset` mid-cycle → all outputs at reset values immediately, `cpu_reset_n`=0.
- Halt: pulse `start`, drive PC 0,2,4,6,6,6 → `cpu_reset_n` low exactly 2 cycles; `done`=1, `halted`=1, `timeout`=0, `cycle_count`=6 after the 6th RUN edge.
- Timeout: PC increments by 2 every cycle → `done`=1, `timeout`=1, `cycle_count`=20. `start` pulsed during RUN has no effect.
- Priority: PC reaches its second repeat on RUN cycle 20 → `halted`=1, `timeout`=0.
- Signature (`MIPS_RUN_MON_SIG_EN` set): `result_i`=16'h0001 for 4 cycles then halt → `signature` matches the reference-model MISR value from seed FFFF. With the macro undefined → `signature`=16'hFFFF.
- Restart and mid-run reset: `start` in DONE → flags clear, new run matches the first. `reset` during RUN → IDLE, then `start` → `cycle_count` begins from 0.
